// File: rtl/br_alu_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : br_alu_mem_sequencer
// Description : Multi-cycle controller for the register-file / ALU / data-memory
//               datapath. Accepts one micro-op per valid/ready handshake and
//               walks it through READ, EXEC (with extra mul/div wait cycles),
//               WB and DONE. Every output is a flop, so the datapath control
//               lines switch cleanly on clock edges.
// Revision    : 1.0 - initial release
// ============================================================================
module br_alu_mem_sequencer #(
   parameter int MUL_WAIT = 2,
   parameter int DIV_WAIT = 8,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [4:0]       cmd_rs,
   input  logic [4:0]       cmd_rt,
   input  logic [4:0]       cmd_rd,
   input  logic             cmd_wb_reg,
   input  logic             cmd_wb_mem,
   input  logic [4:0]       cmd_mem_addr,
   output logic [4:0]       dp_ra1,
   output logic [4:0]       dp_ra2,
   output logic [2:0]       dp_sel,
   output logic [4:0]       dp_dirr,
   output logic             dp_regwrite,
   output logic [4:0]       dp_dir,
   output logic             dp_ewr,
   input  logic             dp_zf,
   output logic             busy,
   output logic             done,
   output logic             done_zf,
   output logic [CNT_W-1:0] op_count
);

   // Wait counter is sized for the longer of the two multi-cycle operations.
   localparam int c_MAX_WAIT = (MUL_WAIT > DIV_WAIT) ? MUL_WAIT : DIV_WAIT;
   localparam int c_WAIT_W   = (c_MAX_WAIT < 1) ? 1 : $clog2(c_MAX_WAIT + 1);
   localparam logic [c_WAIT_W-1:0] c_MUL_CNT = c_WAIT_W'(MUL_WAIT);
   localparam logic [c_WAIT_W-1:0] c_DIV_CNT = c_WAIT_W'(DIV_WAIT);
   localparam logic [2:0] c_OP_MUL = 3'b100;
   localparam logic [2:0] c_OP_DIV = 3'b000;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_EXEC = 3'd2,
      S_WB   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [2:0]          r_op;
   logic [4:0]          r_rd;
   logic [4:0]          r_memAddr;
   logic                r_wbReg;
   logic                r_wbMem;
   logic [c_WAIT_W-1:0] r_waitCnt;
   logic [c_WAIT_W-1:0] w_waitLoad;
   logic                w_accept;
   logic                w_wbNext;

   assign w_accept = (r_state == S_IDLE) && cmd_valid;
   assign w_wbNext = (w_nextState == S_WB);

   // Extra EXEC cycles depend on the latched ALU select.
   always_comb begin
      w_waitLoad = '0;
      case (r_op)
         c_OP_MUL: w_waitLoad = c_MUL_CNT;
         c_OP_DIV: w_waitLoad = c_DIV_CNT;
         default:  w_waitLoad = '0;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_nextState;
   end

   // Next-state logic: fixed walk through the phases, EXEC held by the wait counter.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:  if (cmd_valid) w_nextState = S_READ;
         S_READ:  w_nextState = S_EXEC;
         S_EXEC:  if (r_waitCnt == '0) w_nextState = S_WB;
         S_WB:    w_nextState = S_DONE;
         S_DONE:  w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   // Capture the command fields at the handshake; later input changes are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_op      <= 3'd0;
         r_rd      <= 5'd0;
         r_memAddr <= 5'd0;
         r_wbReg   <= 1'b0;
         r_wbMem   <= 1'b0;
      end else if (w_accept) begin
         r_op      <= cmd_op;
         r_rd      <= cmd_rd;
         r_memAddr <= cmd_mem_addr;
         r_wbReg   <= cmd_wb_reg;
         r_wbMem   <= cmd_wb_mem;
      end
   end

   // Wait counter loads while in READ so it holds W on the first EXEC cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_waitCnt <= '0;
      end else if (r_state == S_READ) begin
         r_waitCnt <= w_waitLoad;
      end else if ((r_state == S_EXEC) && (r_waitCnt != '0)) begin
         r_waitCnt <= r_waitCnt - 1'b1;
      end
   end

   // Registered outputs, decoded from the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_ready   <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         done_zf     <= 1'b0;
         op_count    <= '0;
         dp_ra1      <= 5'd0;
         dp_ra2      <= 5'd0;
         dp_sel      <= 3'd0;
         dp_dirr     <= 5'd0;
         dp_regwrite <= 1'b0;
         dp_dir      <= 5'd0;
         dp_ewr      <= 1'b0;
      end else begin
         cmd_ready   <= (w_nextState == S_IDLE);
         busy        <= (w_nextState != S_IDLE);
         done        <= (w_nextState == S_DONE);
         // Register 0 is hard-wired, so a write to it is suppressed.
         dp_regwrite <= w_wbNext && r_wbReg && (r_rd != 5'd0);
         dp_dirr     <= w_wbNext ? r_rd : 5'd0;
         dp_ewr      <= w_wbNext && r_wbMem;
         dp_dir      <= w_wbNext ? r_memAddr : 5'd0;
         if (r_state == S_WB) begin
            done_zf <= dp_zf;
         end
         if (w_nextState == S_DONE) begin
            op_count <= op_count + 1'b1;
         end
         // Operand addresses and ALU select stay up from READ through WB.
         if (w_accept) begin
            dp_ra1 <= cmd_rs;
            dp_ra2 <= cmd_rt;
            dp_sel <= cmd_op;
         end else if ((w_nextState == S_DONE) || (w_nextState == S_IDLE)) begin
            dp_ra1 <= 5'd0;
            dp_ra2 <= 5'd0;
            dp_sel <= 3'd0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_br_alu_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_br_alu_mem_sequencer
// Description : Self-checking bench for br_alu_mem_sequencer. A timeline model
//               derives every output for cycle k after acceptance from the
//               command alone (operand phase, single write-back cycle, done
//               pulse, counters) and is compared cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_br_alu_mem_sequencer;
   localparam int MUL_WAIT = 2;
   localparam int DIV_WAIT = 8;
   localparam int CNT_W    = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [4:0]       cmd_rs, cmd_rt, cmd_rd, cmd_mem_addr;
   logic             cmd_wb_reg, cmd_wb_mem;
   logic [4:0]       dp_ra1, dp_ra2, dp_dirr, dp_dir;
   logic [2:0]       dp_sel;
   logic             dp_regwrite, dp_ewr, dp_zf;
   logic             busy, done, done_zf;
   logic [CNT_W-1:0] op_count;

   int nChecks = 0;
   int nErrors = 0;

   // Reference command and the architectural state seen before it.
   logic [2:0]  mOp;
   logic [4:0]  mRs, mRt, mRd, mAddr;
   logic        mWbReg, mWbMem, mZf;
   logic [15:0] prevCnt;
   logic        prevZf;

   br_alu_mem_sequencer #(
      .MUL_WAIT(MUL_WAIT), .DIV_WAIT(DIV_WAIT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
      .cmd_wb_reg(cmd_wb_reg), .cmd_wb_mem(cmd_wb_mem), .cmd_mem_addr(cmd_mem_addr),
      .dp_ra1(dp_ra1), .dp_ra2(dp_ra2), .dp_sel(dp_sel), .dp_dirr(dp_dirr),
      .dp_regwrite(dp_regwrite), .dp_dir(dp_dir), .dp_ewr(dp_ewr), .dp_zf(dp_zf),
      .busy(busy), .done(done), .done_zf(done_zf), .op_count(op_count)
   );

   always #5 clk = ~clk;

   // Cycle index (after acceptance) of the single write-back cycle.
   function automatic int wbCycle(input logic [2:0] op);
      int w;
      w = (op == 3'b100) ? MUL_WAIT : ((op == 3'b000) ? DIV_WAIT : 0);
      return 3 + w;
   endfunction

   // Expected outputs k cycles after the accepting edge.
   function automatic logic [44:0] modelOut(input int k);
      int          wb;
      logic        rdy, bsy, dn, zf, rw, ew;
      logic [4:0]  ra1, ra2, dirr, dir;
      logic [2:0]  sel;
      logic [15:0] cnt;
      wb   = wbCycle(mOp);
      rdy  = (k >= wb + 2);
      bsy  = (k <= wb + 1);
      dn   = (k == wb + 1);
      zf   = (k > wb) ? mZf : prevZf;
      ra1  = (k <= wb) ? mRs : 5'd0;
      ra2  = (k <= wb) ? mRt : 5'd0;
      sel  = (k <= wb) ? mOp : 3'd0;
      dirr = (k == wb) ? mRd : 5'd0;
      rw   = (k == wb) && mWbReg && (mRd != 5'd0);
      dir  = (k == wb) ? mAddr : 5'd0;
      ew   = (k == wb) && mWbMem;
      cnt  = (k > wb) ? prevCnt + 16'd1 : prevCnt;
      return {rdy, bsy, dn, zf, ra1, ra2, sel, dirr, rw, dir, ew, cnt};
   endfunction

   function automatic logic [44:0] idleVec(input logic [15:0] cnt, input logic zf);
      return {1'b1, 1'b0, 1'b0, zf, 25'd0, cnt};
   endfunction

   function automatic logic [44:0] obsOut();
      return {cmd_ready, busy, done, done_zf, dp_ra1, dp_ra2, dp_sel, dp_dirr,
              dp_regwrite, dp_dir, dp_ewr, op_count};
   endfunction

   task automatic pickCmd(input logic [2:0] op);
      mOp    = op;
      mRs    = 5'($urandom);
      mRt    = 5'($urandom);
      mRd    = 5'($urandom);
      mAddr  = 5'($urandom);
      mWbReg = 1'($urandom);
      mWbMem = 1'($urandom);
      mZf    = 1'($urandom);
   endtask

   task automatic driveCmd();
      cmd_op       = mOp;
      cmd_rs       = mRs;
      cmd_rt       = mRt;
      cmd_rd       = mRd;
      cmd_wb_reg   = mWbReg;
      cmd_wb_mem   = mWbMem;
      cmd_mem_addr = mAddr;
   endtask

   task automatic scramble();
      cmd_op       = 3'($urandom);
      cmd_rs       = 5'($urandom);
      cmd_rt       = 5'($urandom);
      cmd_rd       = 5'($urandom);
      cmd_wb_reg   = 1'($urandom);
      cmd_wb_mem   = 1'($urandom);
      cmd_mem_addr = 5'($urandom);
   endtask

   function automatic logic [2:0] simpleOp(input int idx);
      case (idx)
         0: return 3'b111;
         1: return 3'b110;
         2: return 3'b011;
         3: return 3'b001;
         4: return 3'b010;
         default: return 3'b101;
      endcase
   endfunction

   task automatic test_reset();
      logic [44:0] obs;
      reset = 1'b1;
      cmd_valid = 1'b0;
      scramble();
      dp_zf = 1'b1;
      repeat (2) @(negedge clk);
      obs = obsOut();
      nChecks++;
      if (obs !== idleVec(16'd0, 1'b0)) begin
         nErrors++;
         $display("FAIL reset_hold got=%h exp=%h", obs, idleVec(16'd0, 1'b0));
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      obs = obsOut();
      nChecks++;
      if (obs !== idleVec(16'd0, 1'b0)) begin
         nErrors++;
         $display("FAIL reset_idle got=%h exp=%h", obs, idleVec(16'd0, 1'b0));
      end
      prevCnt = 16'd0;
      prevZf  = 1'b0;
   endtask

   task automatic test_add();
      logic [44:0] obs, exp;
      int wb;
      for (int n = 0; n < 7; n++) begin
         if (n == 0) begin
            mOp = 3'b111; mRs = 5'd1; mRt = 5'd2; mRd = 5'd3; mAddr = 5'd0;
            mWbReg = 1'b1; mWbMem = 1'b0; mZf = 1'($urandom);
         end else begin
            pickCmd(simpleOp($urandom_range(5, 0)));
         end
         driveCmd();
         cmd_valid = 1'b1;
         wb = wbCycle(mOp);
         for (int k = 1; k <= wb + 2; k++) begin
            @(negedge clk);
            exp = modelOut(k);
            obs = obsOut();
            nChecks++;
            if (obs !== exp) begin
               nErrors++;
               $display("FAIL add_logic n=%0d k=%0d got=%h exp=%h", n, k, obs, exp);
            end
            if (k == 1) begin
               cmd_valid = 1'b0;
               scramble();
            end
            dp_zf = (k == wb) ? mZf : 1'($urandom);
         end
         prevCnt = prevCnt + 16'd1;
         prevZf  = mZf;
      end
   endtask

   task automatic test_muldiv();
      logic [44:0] obs, exp;
      int wb;
      for (int n = 0; n < 4; n++) begin
         pickCmd((n % 2 == 0) ? 3'b000 : 3'b100);
         driveCmd();
         cmd_valid = 1'b1;
         wb = wbCycle(mOp);
         for (int k = 1; k <= wb + 2; k++) begin
            @(negedge clk);
            exp = modelOut(k);
            obs = obsOut();
            nChecks++;
            if (obs !== exp) begin
               nErrors++;
               $display("FAIL mul_div n=%0d op=%b k=%0d got=%h exp=%h", n, mOp, k, obs, exp);
            end
            if (k == 1) begin
               cmd_valid = 1'b0;
               scramble();
            end
            dp_zf = (k == wb) ? mZf : 1'($urandom);
         end
         prevCnt = prevCnt + 16'd1;
         prevZf  = mZf;
      end
   endtask

   task automatic test_reg0();
      logic [44:0] obs, exp;
      int wb;
      pickCmd(simpleOp($urandom_range(5, 0)));
      mRd = 5'd0; mWbReg = 1'b1; mWbMem = 1'b1; mAddr = 5'd25;
      driveCmd();
      cmd_valid = 1'b1;
      wb = wbCycle(mOp);
      for (int k = 1; k <= wb + 2; k++) begin
         @(negedge clk);
         exp = modelOut(k);
         obs = obsOut();
         nChecks++;
         if (obs !== exp) begin
            nErrors++;
            $display("FAIL reg0_mem k=%0d got=%h exp=%h", k, obs, exp);
         end
         if (k == 1) begin
            cmd_valid = 1'b0;
            scramble();
         end
         dp_zf = (k == wb) ? mZf : 1'($urandom);
      end
      prevCnt = prevCnt + 16'd1;
      prevZf  = mZf;
   endtask

   task automatic test_back_to_back();
      logic [44:0] obs, exp;
      int wb;
      pickCmd(3'b111);
      driveCmd();
      cmd_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         wb = wbCycle(mOp);
         for (int k = 1; k <= wb + 2; k++) begin
            @(negedge clk);
            exp = modelOut(k);
            obs = obsOut();
            nChecks++;
            if (obs !== exp) begin
               nErrors++;
               $display("FAIL back_to_back c=%0d k=%0d got=%h exp=%h", c, k, obs, exp);
            end
            dp_zf = (k == wb) ? mZf : 1'($urandom);
            if (k <= wb + 1) begin
               scramble();
            end else begin
               prevCnt = prevCnt + 16'd1;
               prevZf  = mZf;
               if (c < 2) begin
                  pickCmd(3'b111);
                  if (c == 1) mZf = 1'b1;
                  driveCmd();
               end else begin
                  cmd_valid = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic test_reset_midop();
      logic [44:0] obs, exp;
      pickCmd(3'b000);
      mRd = 5'd7; mWbReg = 1'b1; mWbMem = 1'b1;
      driveCmd();
      cmd_valid = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         exp = modelOut(k);
         obs = obsOut();
         nChecks++;
         if (obs !== exp) begin
            nErrors++;
            $display("FAIL reset_midop_pre k=%0d got=%h exp=%h", k, obs, exp);
         end
         if (k == 1) begin
            cmd_valid = 1'b0;
            scramble();
         end
         dp_zf = 1'($urandom);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      prevCnt = 16'd0;
      prevZf  = 1'b0;
      for (int i = 0; i < 12; i++) begin
         obs = obsOut();
         nChecks++;
         if (obs !== idleVec(prevCnt, prevZf)) begin
            nErrors++;
            $display("FAIL reset_midop_post i=%0d got=%h exp=%h", i, obs, idleVec(prevCnt, prevZf));
         end
         dp_zf = 1'($urandom);
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_add();
      test_muldiv();
      test_reg0();
      test_back_to_back();
      test_reset_midop();
      test_reg0();
      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
`default_nettype wire
